// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_arbiter data-memory sequencer.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int unsigned SIZE_WORD = 4;
  localparam int unsigned SIZE_HALF = 2;
  localparam logic        PORT_CPU  = 1'b0;
  localparam logic        PORT_DMA  = 1'b1;

  typedef struct packed {
    logic        we;
    logic        len;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dm_req_check.sv
// Combinational alignment / range / length check for one dm request.
module dm_req_check
  import dm_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic [31:0] addr,
  input  logic        len,
  input  logic        we,
  output logic        ok
);

  logic [32:0] last_byte;
  logic        misaligned;
  logic        out_of_range;
  logic        bad_write;

  always_comb begin
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    last_byte    = {1'b0, addr} + 33'(len ? SIZE_HALF : SIZE_WORD) - 33'd1;
    misaligned   = len ? addr[0] : (addr[1:0] != 2'b00);
    out_of_range = last_byte > 33'(MEM_BYTES - 1);
    bad_write    = we & len;
    ok           = !(misaligned | out_of_range | bad_write);
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for data memory dm; one access at a time.
// Define DM_ARB_RR_EN for round-robin ties, otherwise port 0 has fixed priority.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_0,
  input  logic        we_0,
  input  logic        len_0,
  input  logic [31:0] addr_0,
  input  logic [31:0] wdata_0,
  output logic        done_0,
  output logic [31:0] rdata_0,
  output logic        err_0,
  input  logic        req_1,
  input  logic        we_1,
  input  logic        len_1,
  input  logic [31:0] addr_1,
  input  logic [31:0] wdata_1,
  output logic        done_1,
  output logic [31:0] rdata_1,
  output logic        err_1,
  output logic [31:0] dm_addr,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic        dm_length,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  state_t      state;
  logic        win;
  logic        grant;
  logic        any_req;
  req_t        cand;
  logic        cand_ok;
  logic [31:0] rd_word;
  logic [1:0]  done_q;
  logic [1:0]  err_q;
  logic [31:0] rdata_q [2];

`ifdef DM_ARB_RR_EN
  logic rr_ptr;  // port that wins the next tie

  always_comb grant = (req_0 && req_1) ? rr_ptr : req_1;
`else
  always_comb grant = req_0 ? PORT_CPU : PORT_DMA;
`endif

  assign any_req = req_0 | req_1;

  always_comb begin
    // NOTE: assign a default before any condition so no path leaves cand unassigned (latch).
    cand = '{we: we_0, len: len_0, addr: addr_0, wdata: wdata_0};
    if (grant == PORT_DMA) cand = '{we: we_1, len: len_1, addr: addr_1, wdata: wdata_1};
  end

  dm_req_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .addr(cand.addr),
    .len (cand.len),
    .we  (cand.we),
    .ok  (cand_ok)
  );

  // Halfwords come back right-aligned from dm and are zero-extended here.
  assign rd_word = dm_length ? {16'h0000, dm_rdata[15:0]} : dm_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win        <= PORT_CPU;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      dm_addr    <= '0;
      dm_rd      <= 1'b0;
      dm_wr      <= 1'b0;
      dm_length  <= 1'b0;
      dm_wdata   <= '0;
`ifdef DM_ARB_RR_EN
      rr_ptr     <= PORT_CPU;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (state)
        IDLE: begin
          if (any_req) begin
            win <= grant;
`ifdef DM_ARB_RR_EN
            rr_ptr <= ~grant;
`endif
            if (cand_ok) begin
              dm_addr   <= cand.addr;
              dm_length <= cand.len;
              dm_wdata  <= cand.wdata;
              dm_wr     <= cand.we;
              dm_rd     <= ~cand.we;
              state     <= ACCESS;
            end else begin
              done_q[grant] <= 1'b1;
              err_q[grant]  <= 1'b1;
              state         <= DONE;
            end
          end
        end
        ACCESS: begin
          dm_rd        <= 1'b0;
          dm_wr        <= 1'b0;
          done_q[win]  <= 1'b1;
          rdata_q[win] <= dm_rd ? rd_word : '0;
          state        <= DONE;
        end
        DONE: begin
          done_q     <= '0;
          err_q      <= '0;
          rdata_q[0] <= '0;
          rdata_q[1] <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done_0  = done_q[0];
  assign done_1  = done_q[1];
  assign err_0   = err_q[0];
  assign err_1   = err_q[1];
  assign rdata_0 = rdata_q[0];
  assign rdata_1 = rdata_q[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: byte-array dm model plus a transaction-level reference.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int MEM_BYTES = 128;
`ifdef DM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_0, we_0, len_0, done_0, err_0;
  logic        req_1, we_1, len_1, done_1, err_1;
  logic [31:0] addr_0, wdata_0, rdata_0, addr_1, wdata_1, rdata_1;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_rd, dm_wr, dm_length;

  logic        p_req [2];
  logic        p_we [2];
  logic        p_len [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];

  logic [7:0]  dm_mem [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        load_mem;
  longint      env_a;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;
  int last_port = 1;

  typedef struct {
    int          cyc;
    int          port;
    logic        err;
    logic [31:0] rdata;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  always #5 clk = ~clk;

  assign req_0 = p_req[0];
  assign we_0 = p_we[0];
  assign len_0 = p_len[0];
  assign addr_0 = p_addr[0];
  assign wdata_0 = p_wdata[0];
  assign req_1 = p_req[1];
  assign we_1 = p_we[1];
  assign len_1 = p_len[1];
  assign addr_1 = p_addr[1];
  assign wdata_1 = p_wdata[1];

  dm_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .we_0(we_0), .len_0(len_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .done_0(done_0), .rdata_0(rdata_0), .err_0(err_0),
    .req_1(req_1), .we_1(we_1), .len_1(len_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .done_1(done_1), .rdata_1(rdata_1), .err_1(err_1),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_length(dm_length),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // Memory dm: combinational read, big-endian 4-byte write on the clock edge.
  always_comb begin
    env_a    = longint'({32'h0, dm_addr});
    dm_rdata = '0;
    if (dm_length) begin
      if (env_a + 1 < MEM_BYTES) dm_rdata = {16'h0000, dm_mem[env_a], dm_mem[env_a + 1]};
    end else if (env_a + 3 < MEM_BYTES) begin
      dm_rdata = {dm_mem[env_a], dm_mem[env_a + 1], dm_mem[env_a + 2], dm_mem[env_a + 3]};
    end
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < MEM_BYTES; i++) dm_mem[i] <= ref_mem[i];
    end else if (dm_wr) begin
      for (int i = 0; i < 4; i++)
        if (env_a + i < MEM_BYTES) dm_mem[env_a + i] <= dm_wdata[31 - 8 * i -: 8];
    end
  end

  always @(negedge clk) begin
    if (dm_wr) wr_cycles++;
    if (dm_rd) rd_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference rules, written as plain arithmetic on the request fields.
  function automatic bit ref_reject(input logic we, input logic len, input logic [31:0] addr);
    longint size;
    longint a;
    size = len ? 2 : 4;
    a    = longint'({32'h0, addr});
    if (!len && (a % 4) != 0) return 1'b1;
    if (len && (a % 2) != 0) return 1'b1;
    if (a + size - 1 > MEM_BYTES - 1) return 1'b1;
    if (we && len) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_read(input logic len, input logic [31:0] addr);
    int a;
    a = int'(addr);
    if (len) return {16'h0000, ref_mem[a], ref_mem[a + 1]};
    return {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] data);
    int a;
    a = int'(addr);
    for (int i = 0; i < 4; i++) ref_mem[a + i] = data[31 - 8 * i -: 8];
  endtask

  // Hold the chosen requests for `cycles` edges, then drain and compare completions.
  task automatic run_held(input bit r0, input bit r1, input int cycles, input string name);
    int   g, w, wr0, rd0, exp_wr, exp_rd, junk;
    bit   rej;
    ev_t  e;
    exp_q.delete();
    obs_q.delete();
    exp_wr = 0;
    exp_rd = 0;
    junk   = 0;
    wr0    = wr_cycles;
    rd0    = rd_cycles;
    g      = 1;
    while (g <= cycles && (r0 || r1)) begin
      if (r0 && r1) w = RR_MODE ? (last_port == 0 ? 1 : 0) : 0;
      else w = r1 ? 1 : 0;
      last_port = w;
      rej       = ref_reject(p_we[w], p_len[w], p_addr[w]);
      e.port    = w;
      e.err     = rej;
      e.rdata   = '0;
      if (!rej) begin
        if (p_we[w]) begin
          ref_write(p_addr[w], p_wdata[w]);
          exp_wr++;
        end else begin
          e.rdata = ref_read(p_len[w], p_addr[w]);
          exp_rd++;
        end
      end
      e.cyc = rej ? g : g + 1;
      exp_q.push_back(e);
      g = e.cyc + 2;
    end
    p_req[0] = r0;
    p_req[1] = r1;
    for (int k = 1; k <= cycles + 4; k++) begin
      @(posedge clk);
      #1;
      if (done_0) begin
        e.cyc = k; e.port = 0; e.err = err_0; e.rdata = rdata_0;
        obs_q.push_back(e);
      end else if (err_0 || rdata_0 != 0) junk++;
      if (done_1) begin
        e.cyc = k; e.port = 1; e.err = err_1; e.rdata = rdata_1;
        obs_q.push_back(e);
      end else if (err_1 || rdata_1 != 0) junk++;
      if (k == cycles) begin
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
      end
    end
    check({name, ":n_done"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s:ev%0d_cyc", name, i), obs_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s:ev%0d_port", name, i), obs_q[i].port, exp_q[i].port);
      check($sformatf("%s:ev%0d_err", name, i), {31'h0, obs_q[i].err}, {31'h0, exp_q[i].err});
      check($sformatf("%s:ev%0d_rdata", name, i), obs_q[i].rdata, exp_q[i].rdata);
    end
    check({name, ":wr_cycles"}, wr_cycles - wr0, exp_wr);
    check({name, ":rd_cycles"}, rd_cycles - rd0, exp_rd);
    check({name, ":idle_outs"}, junk, 0);
  endtask

  task automatic set_port(input int p, input logic we, input logic len,
                          input logic [31:0] addr, input logic [31:0] wdata);
    p_we[p]    = we;
    p_len[p]   = len;
    p_addr[p]  = addr;
    p_wdata[p] = wdata;
  endtask

  // One protocol-conforming transfer: request held exactly until done.
  task automatic single(input int p, input logic we, input logic len,
                        input logic [31:0] addr, input logic [31:0] wdata, input string name);
    set_port(p, we, len, addr, wdata);
    run_held(p == 0, p == 1, ref_reject(we, len, addr) ? 1 : 2, name);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ":ctl"}, {25'h0, done_0, done_1, err_0, err_1, dm_rd, dm_wr, dm_length}, 32'h0);
    check({name, ":rdata_0"}, rdata_0, 32'h0);
    check({name, ":rdata_1"}, rdata_1, 32'h0);
    check({name, ":dm_addr"}, dm_addr, 32'h0);
    check({name, ":dm_wdata"}, dm_wdata, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    return 32'($urandom_range(0, MEM_BYTES + 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0;
      set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    load_mem = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    load_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    single(0, 1'b1, 1'b0, 32'd8, 32'hDEADBEEF, "wr8");
    single(0, 1'b0, 1'b0, 32'd8, 32'h0, "rd8");
    single(0, 1'b0, 1'b1, 32'd10, 32'h0, "rdh10");
    single(0, 1'b0, 1'b0, 32'd6, 32'h0, "err_misalign");
    single(0, 1'b0, 1'b0, 32'd126, 32'h0, "err_range");
    single(0, 1'b1, 1'b1, 32'd4, 32'h12345678, "err_halfwr");
    single(1, 1'b0, 1'b0, 32'd124, 32'h0, "rd124");
    single(1, 1'b0, 1'b1, 32'd126, 32'h0, "rdh126");
    single(1, 1'b0, 1'b1, 32'd127, 32'h0, "err_odd_half");
    single(1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, "err_wrap");

    set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'd8, 32'h0);
    run_held(1'b1, 1'b1, 12, "tie");
    run_held(1'b1, 1'b0, 9, "thru");
    set_port(1, 1'b0, 1'b0, 32'd2, 32'h0);
    run_held(1'b0, 1'b1, 6, "thru_err");

    for (int t = 0; t < 30; t++) begin
      for (int p = 0; p < 2; p++)
        set_port(p, 1'($urandom), 1'($urandom_range(0, 3) == 0), rand_addr(), $urandom);
      run_held(1'($urandom), 1'($urandom), $urandom_range(1, 10), $sformatf("rnd%0d", t));
    end

    // Reset in the ACCESS cycle of a write: strobe drops at once, memory untouched.
    set_port(0, 1'b1, 1'b0, 32'd0, 32'h11223344);
    p_req[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid:dm_wr_access", {31'h0, dm_wr}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    p_req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid:no_done", {30'h0, done_0, done_1}, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    last_port = 1;
    @(posedge clk);
    #1;
    single(0, 1'b0, 1'b0, 32'd0, 32'h0, "rd0_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
